// File: rtl/overlay_ctrl_pkg.sv
// Shared constants for the overlay control master: register map, status/ctrl bits,
// error codes and AXI response encodings.
package overlay_ctrl_pkg;

  localparam logic [7:0] RegCtrl   = 8'h00;
  localparam logic [7:0] RegStatus = 8'h04;
  localparam logic [7:0] RegWidth  = 8'h08;
  localparam logic [7:0] RegHeigth = 8'h0C;
  localparam logic [7:0] RegHloc   = 8'h10;
  localparam logic [7:0] RegVloc   = 8'h14;

  localparam int unsigned CtrlRunBit    = 0;
  localparam int unsigned StatusDoneBit = 0;
  localparam int unsigned NumWrites     = 5;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrBresp   = 2'd1,
    ErrTimeout = 2'd2
  } err_code_e;

  // Register offset for each step of the programming sequence.
  function automatic logic [7:0] wr_offset(input logic [2:0] idx);
    case (idx)
      3'd0:    return RegWidth;
      3'd1:    return RegHeigth;
      3'd2:    return RegHloc;
      3'd3:    return RegVloc;
      default: return RegCtrl;
    endcase
  endfunction

endpackage

// File: rtl/overlay_ctrl_master_if.sv
// AXI4-Lite channel bundle between the overlay control master and its slave.
interface overlay_ctrl_master_if #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32
) ();
  logic [AddrWidth-1:0] awaddr;
  logic                 awvalid;
  logic                 awready;
  logic [DataWidth-1:0] wdata;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [AddrWidth-1:0] araddr;
  logic                 arvalid;
  logic                 arready;
  logic [DataWidth-1:0] rdata;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rvalid
  );
endinterface

// File: rtl/axil_single_master.sv
// Single-beat AXI4-Lite engine: one write or read at a time, AW and W complete independently.
module axil_single_master #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 wr_start_i,
  input  logic                 rd_start_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 wr_done_o,
  output logic [1:0]           bresp_o,
  output logic                 rd_done_o,
  output logic [DataWidth-1:0] rdata_o,
  overlay_ctrl_master_if.master axi
);

  typedef enum logic [2:0] {PhIdle, PhWrite, PhWrResp, PhRdAddr, PhRdData} phase_e;

  phase_e               phase_q, phase_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 arvalid_q, arvalid_d;
  logic [AddrWidth-1:0] awaddr_q, awaddr_d;
  logic [AddrWidth-1:0] araddr_q, araddr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 free;

  assign wr_done_o = (phase_q == PhWrResp) && axi.bvalid;
  assign rd_done_o = (phase_q == PhRdData) && axi.rvalid;
  assign bresp_o   = axi.bresp;
  assign rdata_o   = axi.rdata;
  // A new request may be accepted in the very cycle the previous one completes.
  assign free      = (phase_q == PhIdle) || wr_done_o || rd_done_o;

  always_comb begin
    phase_d   = phase_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    unique case (phase_q)
      PhWrite: begin
        if (axi.awready) awvalid_d = 1'b0;
        if (axi.wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) phase_d = PhWrResp;
      end
      PhWrResp: if (wr_done_o) phase_d = PhIdle;
      PhRdAddr: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          phase_d   = PhRdData;
        end
      end
      PhRdData: if (rd_done_o) phase_d = PhIdle;
      default: ;
    endcase
    if (free && wr_start_i) begin
      phase_d   = PhWrite;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = addr_i;
      wdata_d   = wdata_i;
    end else if (free && rd_start_i) begin
      phase_d   = PhRdAddr;
      arvalid_d = 1'b1;
      araddr_d  = addr_i;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      phase_q   <= PhIdle;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      phase_q   <= phase_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.bready  = (phase_q == PhWrResp);
  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.rready  = (phase_q == PhRdData);

endmodule

// File: rtl/overlay_ctrl_master.sv
// Programs the overlay control slave (geometry then CTRL.run) and polls STATUS.done
// with a bounded number of reads, reporting success or the failure cause.
module overlay_ctrl_master
  import overlay_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth    = 8,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned PollInterval = 16,
  parameter int unsigned PollTimeout  = 1024
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 start_i,
  input  logic [DataWidth-1:0] cfg_width_i,
  input  logic [DataWidth-1:0] cfg_heigth_i,
  input  logic [DataWidth-1:0] cfg_hlocation_i,
  input  logic [DataWidth-1:0] cfg_vlocation_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [1:0]           error_code_o,
  overlay_ctrl_master_if.master axi
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StWait, StOk, StErr} state_e;

  localparam int unsigned PollCntW = $clog2(PollTimeout + 1);
  localparam int unsigned WaitCntW = $clog2(PollInterval + 1);
  localparam logic [PollCntW-1:0]  PollLast   = PollCntW'(PollTimeout - 1);
  localparam logic [WaitCntW-1:0]  WaitLast   = WaitCntW'(PollInterval - 1);
  localparam logic [2:0]           LastIdx    = 3'(NumWrites - 1);
  localparam logic [DataWidth-1:0] CtrlRunVal = DataWidth'(1) << CtrlRunBit;

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d, idx_inc;
  logic [DataWidth-1:0] width_q, width_d, heigth_q, heigth_d;
  logic [DataWidth-1:0] hloc_q, hloc_d, vloc_q, vloc_d;
  logic [PollCntW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [WaitCntW-1:0]  wait_cnt_q, wait_cnt_d;
  logic                 error_q, error_d;
  err_code_e            err_code_q, err_code_d;

  logic                 wr_start, rd_start, wr_done, rd_done;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata, next_wdata, rd_rdata;
  logic [1:0]           bresp;
  logic                 unused_rdata;

  assign idx_inc      = idx_q + 3'd1;
  assign unused_rdata = ^rd_rdata;

  always_comb begin
    case (idx_inc)
      3'd1:    next_wdata = heigth_q;
      3'd2:    next_wdata = hloc_q;
      3'd3:    next_wdata = vloc_q;
      default: next_wdata = CtrlRunVal;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    width_d    = width_q;
    heigth_d   = heigth_q;
    hloc_d     = hloc_q;
    vloc_d     = vloc_q;
    poll_cnt_d = poll_cnt_q;
    wait_cnt_d = wait_cnt_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    wr_start   = 1'b0;
    rd_start   = 1'b0;
    req_addr   = AddrWidth'(RegStatus);
    req_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // First write uses the live cfg value; the shadows are loaded in the same cycle.
          width_d    = cfg_width_i;
          heigth_d   = cfg_heigth_i;
          hloc_d     = cfg_hlocation_i;
          vloc_d     = cfg_vlocation_i;
          error_d    = 1'b0;
          err_code_d = ErrNone;
          idx_d      = '0;
          wr_start   = 1'b1;
          req_addr   = AddrWidth'(wr_offset(3'd0));
          req_wdata  = cfg_width_i;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (wr_done) begin
          if (bresp != RespOkay) begin
            error_d    = 1'b1;
            err_code_d = ErrBresp;
            state_d    = StErr;
          end else if (idx_q != LastIdx) begin
            idx_d     = idx_inc;
            wr_start  = 1'b1;
            req_addr  = AddrWidth'(wr_offset(idx_inc));
            req_wdata = next_wdata;
          end else begin
            rd_start   = 1'b1;
            poll_cnt_d = '0;
            wait_cnt_d = '0;
            state_d    = StRead;
          end
        end
      end
      StRead: begin
        if (rd_done) begin
          if (rd_rdata[StatusDoneBit]) begin
            state_d = StOk;
          end else if (poll_cnt_q == PollLast) begin
            error_d    = 1'b1;
            err_code_d = ErrTimeout;
            state_d    = StErr;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            wait_cnt_d = '0;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          rd_start = 1'b1;
          state_d  = StRead;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StOk, StErr: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      width_q    <= '0;
      heigth_q   <= '0;
      hloc_q     <= '0;
      vloc_q     <= '0;
      poll_cnt_q <= '0;
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      width_q    <= width_d;
      heigth_q   <= heigth_d;
      hloc_q     <= hloc_d;
      vloc_q     <= vloc_d;
      poll_cnt_q <= poll_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign busy_o       = (state_q == StWrite) || (state_q == StRead) || (state_q == StWait);
  assign done_o       = (state_q == StOk) || (state_q == StErr);
  assign error_o      = error_q;
  assign error_code_o = err_code_q;

  axil_single_master #(
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth)
  ) u_engine (
    .axi_aclk   (axi_aclk),
    .axi_aresetn(axi_aresetn),
    .wr_start_i (wr_start),
    .rd_start_i (rd_start),
    .addr_i     (req_addr),
    .wdata_i    (req_wdata),
    .wr_done_o  (wr_done),
    .bresp_o    (bresp),
    .rd_done_o  (rd_done),
    .rdata_o    (rd_rdata),
    .axi        (axi)
  );

endmodule

// File: tb/tb_overlay_ctrl_master.sv
// Bench for overlay_ctrl_master: reactive AXI-Lite slave, write scoreboard, per-scenario tasks.
module tb_overlay_ctrl_master;
  import overlay_ctrl_pkg::*;

  localparam int unsigned PollInterval = 16;
  localparam int unsigned PollTimeout  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [31:0] cfg_w = '0, cfg_h = '0, cfg_hl = '0, cfg_vl = '0;
  logic        busy, done, error;
  logic [1:0]  error_code;

  always #5 clk = ~clk;

  overlay_ctrl_master_if #(.AddrWidth(8), .DataWidth(32)) axi ();

  overlay_ctrl_master #(
    .AddrWidth   (8),
    .DataWidth   (32),
    .PollInterval(PollInterval),
    .PollTimeout (PollTimeout)
  ) dut (
    .axi_aclk       (clk),
    .axi_aresetn    (rst_n),
    .start_i        (start),
    .cfg_width_i    (cfg_w),
    .cfg_heigth_i   (cfg_h),
    .cfg_hlocation_i(cfg_hl),
    .cfg_vlocation_i(cfg_vl),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .error_code_o   (error_code),
    .axi            (axi)
  );

  int checks = 0, passes = 0, cyc = 0;
  int aw_delay = 0, w_delay = 0, err_wr = -1, ok_read = 1;
  int wr_seen = 0, rd_seen = 0, b_seen = 0, aw_run = 0, w_run = 0;
  int aw_lens[$], w_lens[$], rd_times[$];
  logic [39:0] exp_wr[$];
  logic [1:0]  cur_bresp = 2'b00;
  logic [31:0] cur_rdata = '0;
  logic [7:0]  mon_addr = '0, pend_addr = '0;
  logic [31:0] mon_data = '0;
  logic        pend_aw = 1'b0;

  // Reactive slave
  int          aw_cnt = 0, w_cnt = 0;
  logic        got_aw = 1'b0, got_w = 1'b0, bvalid_r = 1'b0, rvalid_r = 1'b0;
  logic [1:0]  bresp_r = 2'b00;
  logic [31:0] rdata_r = '0;
  logic        aw_hs, w_hs;

  assign axi.awready = axi.awvalid && !got_aw && (aw_cnt >= aw_delay);
  assign axi.wready  = axi.wvalid && !got_w && (w_cnt >= w_delay);
  assign axi.arready = axi.arvalid;
  assign axi.bvalid  = bvalid_r;
  assign axi.bresp   = bresp_r;
  assign axi.rvalid  = rvalid_r;
  assign axi.rdata   = rdata_r;
  assign aw_hs       = axi.awvalid && axi.awready;
  assign w_hs        = axi.wvalid && axi.wready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0; bresp_r <= 2'b00; rdata_r <= '0;
    end else begin
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
      if (aw_hs) got_aw <= 1'b1;
      if (w_hs)  got_w  <= 1'b1;
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        bvalid_r <= 1'b1; bresp_r <= cur_bresp; got_aw <= 1'b0; got_w <= 1'b0;
      end else if (bvalid_r && axi.bready) begin
        bvalid_r <= 1'b0;
      end
      if (axi.arvalid && axi.arready) begin
        rvalid_r <= 1'b1; rdata_r <= cur_rdata;
      end else if (rvalid_r && axi.rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard for writes, response selection, read timestamps, AW stability.
  initial forever begin
    logic [39:0] e;
    @(negedge clk);
    if (rst_n !== 1'b1) begin
      pend_aw = 1'b0; aw_run = 0; w_run = 0;
    end else begin
      if (pend_aw) begin
        checks++;
        if (axi.awvalid !== 1'b1 || axi.awaddr !== pend_addr)
          $display("FAIL aw_stable: awvalid=%b awaddr=%h, required awvalid=1 awaddr=%h",
                   axi.awvalid, axi.awaddr, pend_addr);
        else passes++;
      end
      pend_aw   = axi.awvalid && !axi.awready;
      pend_addr = axi.awaddr;
      if (axi.awvalid) aw_run++;
      if (axi.wvalid)  w_run++;
      if (aw_hs) mon_addr = axi.awaddr;
      if (w_hs)  mon_data = axi.wdata;
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        cur_bresp = (wr_seen == err_wr) ? RespSlverr : RespOkay;
        wr_seen++;
        aw_lens.push_back(aw_run); w_lens.push_back(w_run);
        aw_run = 0; w_run = 0;
        checks++;
        if (exp_wr.size() == 0) begin
          $display("FAIL write_order: got write %h=%h, required no write", mon_addr, mon_data);
        end else begin
          e = exp_wr.pop_front();
          if ({mon_addr, mon_data} !== e)
            $display("FAIL write_order: got %h=%h, required %h=%h",
                     mon_addr, mon_data, e[39:32], e[31:0]);
          else passes++;
        end
      end
      if (axi.bvalid && axi.bready) b_seen++;
      if (axi.arvalid && axi.arready) begin
        rd_seen++;
        rd_times.push_back(cyc);
        cur_rdata = (rd_seen >= ok_read) ? 32'h0000_0001 : 32'hFFFF_FFFE;
        checks++;
        if (axi.araddr !== RegStatus)
          $display("FAIL read_addr: got %h, required %h", axi.araddr, RegStatus);
        else passes++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_mon();
    wr_seen = 0; rd_seen = 0; b_seen = 0;
    aw_lens.delete(); w_lens.delete(); rd_times.delete(); exp_wr.delete();
  endtask

  task automatic push_exp(input logic [31:0] w, h, hl, vl, input int n);
    logic [39:0] seq [5];
    seq[0] = {RegWidth, w};  seq[1] = {RegHeigth, h}; seq[2] = {RegHloc, hl};
    seq[3] = {RegVloc, vl};  seq[4] = {RegCtrl, 32'h1};
    for (int i = 0; i < n; i++) exp_wr.push_back(seq[i]);
  endtask

  // Pulses start for one cycle, then scrambles cfg to prove the run uses the captured values.
  task automatic do_start(input logic [31:0] w, h, hl, vl, input int n_exp, output int s);
    push_exp(w, h, hl, vl, n_exp);
    @(negedge clk);
    start = 1'b1; cfg_w = w; cfg_h = h; cfg_hl = hl; cfg_vl = vl; s = cyc;
    @(negedge clk);
    start = 1'b0;
    cfg_w = $urandom(); cfg_h = $urandom(); cfg_hl = $urandom(); cfg_vl = $urandom();
  endtask

  task automatic wait_done(input string name, input int budget, output int at);
    logic got = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; at = cyc; end
    end
    checks++;
    if (!got) $display("FAIL %s_done: got no done pulse within %0d cycles, required pulse", name, budget);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, error_code, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
         axi.rready} !== 10'b0)
      $display("FAIL reset_ctrl: got %b, required 0", {busy, done, error, error_code,
               axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
    else passes++;
    checks++;
    if ({axi.awaddr, axi.wdata, axi.araddr} !== 48'b0)
      $display("FAIL reset_data: got %h, required 0", {axi.awaddr, axi.wdata, axi.araddr});
    else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error} !== 3'b0) $display("FAIL idle_after_reset: got %b, required 000",
                                               {busy, done, error});
    else passes++;
  endtask

  task automatic test_basic();
    int s, at;
    clear_mon(); aw_delay = 0; w_delay = 0; err_wr = -1; ok_read = 1;
    do_start(32'd1920, 32'd1080, 32'd100, 32'd50, 5, s);
    wait_done("basic", 100, at);
    checks++;
    if ({error, error_code, busy} !== 4'b0)
      $display("FAIL basic_status: got err=%b code=%0d busy=%b, required 0/0/0", error, error_code, busy);
    else passes++;
    checks++;
    if (at - s !== 13) $display("FAIL basic_latency: got %0d, required 13", at - s);
    else passes++;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL basic_pulse: got done=%b busy=%b, required 0/0", done, busy);
    else passes++;
    checks++;
    if (wr_seen !== 5 || rd_seen !== 1 || exp_wr.size() !== 0)
      $display("FAIL basic_counts: got wr=%0d rd=%0d left=%0d, required 5/1/0", wr_seen, rd_seen, exp_wr.size());
    else passes++;
    checks++;
    if (rd_times.size() !== 1 || rd_times[0] - s !== 11)
      $display("FAIL basic_first_read: got offset %0d, required 11",
               rd_times.size() ? rd_times[0] - s : -1);
    else passes++;
  endtask

  task automatic test_aw_delay();
    int s, at;
    clear_mon(); aw_delay = 3; w_delay = 0; err_wr = -1; ok_read = 1;
    do_start(32'd640, 32'd480, 32'd7, 32'd9, 5, s);
    wait_done("aw_delay", 150, at);
    @(negedge clk);
    checks++;
    if (aw_lens.size() !== 5 || b_seen !== 5)
      $display("FAIL aw_delay_count: got writes=%0d b=%0d, required 5/5", aw_lens.size(), b_seen);
    else passes++;
    for (int i = 0; i < aw_lens.size(); i++) begin
      checks++;
      if (aw_lens[i] !== 4 || w_lens[i] !== 1)
        $display("FAIL aw_delay_len: write %0d got aw=%0d w=%0d, required 4/1", i, aw_lens[i], w_lens[i]);
      else passes++;
    end
    aw_delay = 0;
  endtask

  task automatic test_poll();
    int s, at;
    clear_mon(); err_wr = -1; ok_read = 4;
    do_start(32'd11, 32'd22, 32'd33, 32'd44, 5, s);
    repeat (20) @(negedge clk);
    start = 1'b1; cfg_w = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    wait_done("poll", 300, at);
    checks++;
    if ({error, error_code} !== 3'b0 || rd_seen !== 4)
      $display("FAIL poll_result: got err=%b code=%0d reads=%0d, required 0/0/4", error, error_code, rd_seen);
    else passes++;
    for (int i = 1; i < rd_times.size(); i++) begin
      checks++;
      if (rd_times[i] - rd_times[i-1] < 16)
        $display("FAIL poll_spacing: read %0d gap %0d, required >=16", i, rd_times[i] - rd_times[i-1]);
      else passes++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (wr_seen !== 5 || busy !== 1'b0)
      $display("FAIL busy_start_ignored: got wr=%0d busy=%b, required 5/0", wr_seen, busy);
    else passes++;
  endtask

  task automatic test_bresp_err();
    int s, at;
    clear_mon(); err_wr = 1; ok_read = 1;
    do_start(32'd5, 32'd6, 32'd7, 32'd8, 2, s);
    wait_done("bresp", 100, at);
    checks++;
    if ({error, error_code, busy} !== 4'b1010)
      $display("FAIL bresp_status: got err=%b code=%0d busy=%b, required 1/1/0", error, error_code, busy);
    else passes++;
    repeat (20) @(negedge clk);
    checks++;
    if (wr_seen !== 2 || rd_seen !== 0 || error !== 1'b1)
      $display("FAIL bresp_stop: got wr=%0d rd=%0d err=%b, required 2/0/1", wr_seen, rd_seen, error);
    else passes++;
    err_wr = -1;
  endtask

  task automatic test_timeout();
    int s, at;
    clear_mon(); err_wr = -1; ok_read = 1000;
    do_start(32'd1, 32'd2, 32'd3, 32'd4, 5, s);
    wait_done("timeout", 400, at);
    checks++;
    if ({error, error_code} !== 3'b110)
      $display("FAIL timeout_status: got err=%b code=%0d, required 1/2", error, error_code);
    else passes++;
    repeat (30) @(negedge clk);
    checks++;
    if (rd_seen !== PollTimeout) $display("FAIL timeout_reads: got %0d, required %0d", rd_seen, PollTimeout);
    else passes++;
    clear_mon(); ok_read = 1;
    do_start(32'd9, 32'd8, 32'd7, 32'd6, 5, s);
    checks++;
    if ({error, error_code, busy} !== 4'b0001)
      $display("FAIL restart_clears: got err=%b code=%0d busy=%b, required 0/0/1", error, error_code, busy);
    else passes++;
    wait_done("restart", 100, at);
    checks++;
    if (error !== 1'b0) $display("FAIL restart_status: got err=%b, required 0", error);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int s, at;
    logic hit = 1'b0;
    clear_mon(); ok_read = 1;
    do_start(32'hAA, 32'hBB, 32'hCC, 32'hDD, 5, s);
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (axi.bready === 1'b1) hit = 1'b1;
    end
    checks++;
    if (!hit) $display("FAIL reset_mid_wresp: got no bready within 50 cycles, required bready");
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, error_code, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
         axi.rready, axi.awaddr, axi.wdata} !== '0)
      $display("FAIL reset_mid_async: got busy=%b bready=%b awaddr=%h, required all 0",
               busy, axi.bready, axi.awaddr);
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    do_start(32'd320, 32'd240, 32'd1, 32'd2, 5, s);
    wait_done("reset_mid", 100, at);
    checks++;
    if (wr_seen !== 5 || error !== 1'b0)
      $display("FAIL reset_mid_rerun: got wr=%0d err=%b, required 5/0", wr_seen, error);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_delay();
    test_poll();
    test_bresp_err();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
